// File: rtl/vga_fb_ctrl.sv
// VGA raster generator with programmable timing, fused with a double-buffered,
// optionally pixel-doubled framebuffer written through a byte-strobed bus port.
module vga_fb_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int SCALE    = 1,
  parameter int ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] CTRL_ADDR =
    ADDR_W'(4 * 2 * (H_ACTIVE / SCALE) * (V_ACTIVE / SCALE))
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [ADDR_W-1:0] WriteAddrIn,
  input  logic [31:0]       WriteDataIn,
  input  logic              WriteEnableIn,
  input  logic [3:0]        WriteStrb,
  output logic              SlaverWriteReady,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic              vblank_irq,
  output logic              swap_pending
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_ACTIVE / SCALE;
  localparam int FB_H    = V_ACTIVE / SCALE;
  localparam int FB_PIX  = FB_W * FB_H;
  localparam int SHIFT   = (SCALE == 2) ? 1 : 0;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int MW      = $clog2(2 * FB_PIX);
  localparam int IW      = ADDR_W - 2;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [MW-1:0] BUF_OFS = MW'(FB_PIX);
  localparam logic [MW-1:0] FB_W_M  = MW'(FB_W);
  localparam logic [IW-1:0] PIX_LIM = IW'(FB_PIX);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          front;
  logic          blank;
  logic          pix_on;
  logic          active;
  logic          swap_point;
  logic          accept;
  logic          pix_hit;
  logic          ctrl_hit;
  logic [IW-1:0] wr_idx;
  logic [MW-1:0] wr_addr;
  logic [MW-1:0] rd_addr;
  logic [23:0]   rd_data;
  logic [23:0]   mem [2*FB_PIX];
  logic          unused_bits;

  assign unused_bits = ^{WriteStrb[3], WriteDataIn[31:24]};

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    swap_point = (h_cnt == '0) && (v_cnt == V_ACT);
    // Gating with clrn keeps a request held through reset from reaching the RAM.
    accept     = clrn && WriteEnableIn && !SlaverWriteReady;
    wr_idx     = WriteAddrIn[ADDR_W-1:2];
    pix_hit    = accept && (wr_idx < PIX_LIM);
    ctrl_hit   = accept && (WriteAddrIn == CTRL_ADDR) && WriteStrb[0];
    wr_addr    = MW'(wr_idx) + (front ? '0 : BUF_OFS);
    rd_addr    = '0;
    if (active)
      rd_addr = MW'(v_cnt >> SHIFT) * FB_W_M + MW'(h_cnt >> SHIFT) + (front ? BUF_OFS : '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt            <= '0;
      v_cnt            <= '0;
      front            <= 1'b0;
      blank            <= 1'b0;
      swap_pending     <= 1'b0;
      SlaverWriteReady <= 1'b0;
      vblank_irq       <= 1'b0;
      hsync            <= ~SYNC_POL;
      vsync            <= ~SYNC_POL;
      valid            <= 1'b0;
      pix_on           <= 1'b0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      hsync      <= ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync      <= ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
      valid      <= active;
      pix_on     <= active && !blank;
      vblank_irq <= swap_point;
      SlaverWriteReady <= accept;

      if (swap_point && swap_pending) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end
      // A request landing on the swap point itself is kept for the next frame.
      if (ctrl_hit) begin
        if (WriteDataIn[0])
          swap_pending <= 1'b1;
        blank <= WriteDataIn[1];
      end
    end
  end

  // NOTE: the framebuffer RAM has no reset; its contents survive clrn and start undefined.
  always_ff @(posedge clk) begin
    if (pix_hit) begin
      if (WriteStrb[0]) mem[wr_addr][7:0]   <= WriteDataIn[7:0];
      if (WriteStrb[1]) mem[wr_addr][15:8]  <= WriteDataIn[15:8];
      if (WriteStrb[2]) mem[wr_addr][23:16] <= WriteDataIn[23:16];
    end
    rd_data <= mem[rd_addr];
  end

  assign vga_r = pix_on ? rd_data[23:16] : 8'h00;
  assign vga_g = pix_on ? rd_data[15:8]  : 8'h00;
  assign vga_b = pix_on ? rd_data[7:0]   : 8'h00;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Self-checking bench for vga_fb_ctrl: a frame-arithmetic reference model checks
// every cycle of a SCALE=1 instance; a SCALE=2 instance covers replication and reset.
module tb_vga_fb_ctrl;

  localparam int HA       = 8;
  localparam int HT       = 14;
  localparam int VA       = 4;
  localparam int VT       = 7;
  localparam int FT       = HT * VT;
  localparam int NPIX     = 32;
  localparam int SWAP_IDX = VA * HT;
  localparam logic [31:0] CTRL1 = 32'd256;
  localparam logic [31:0] CTRL2 = 32'd64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn, clrn2;
  logic [31:0] addr, wdata, addr2, wdata2;
  logic        we, we2;
  logic [3:0]  strb, strb2;
  logic        ready, ready2;
  logic [7:0]  r, g, b, r2, g2, b2;
  logic        hs, vs, vld, irq, pend;
  logic        hs2, vs2, vld2, irq2, pend2;

  int total = 0;
  int bad   = 0;

  // Reference model state: two buffers, which pixels hold defined data, and flags.
  logic [23:0] m_buf   [2][NPIX];
  bit          m_known [2][NPIX];
  bit          m_front, m_pend, m_blank, m_ack;
  int          m_c, p1, c2, p2;
  logic        e_hs, e_vs, e_valid, e_irq, e_ack, e_pend;
  logic [23:0] e_rgb;
  bit          e_rgb_known;

  vga_fb_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .SCALE(1), .ADDR_W(32)
  ) u_dut (
    .clk(clk), .clrn(clrn), .WriteAddrIn(addr), .WriteDataIn(wdata),
    .WriteEnableIn(we), .WriteStrb(strb), .SlaverWriteReady(ready),
    .vga_r(r), .vga_g(g), .vga_b(b), .hsync(hs), .vsync(vs), .valid(vld),
    .vblank_irq(irq), .swap_pending(pend)
  );

  vga_fb_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .SCALE(2), .ADDR_W(32)
  ) u_dut2 (
    .clk(clk), .clrn(clrn2), .WriteAddrIn(addr2), .WriteDataIn(wdata2),
    .WriteEnableIn(we2), .WriteStrb(strb2), .SlaverWriteReady(ready2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2), .hsync(hs2), .vsync(vs2), .valid(vld2),
    .vblank_irq(irq2), .swap_pending(pend2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after this edge, derived from the frame position m_c.
  task automatic model_step();
    int h, v, pi;
    bit acc, bk;
    if (!clrn) begin
      m_c = 0; p1 = -1; m_front = 0; m_pend = 0; m_blank = 0; m_ack = 0;
      e_hs = 1; e_vs = 1; e_valid = 0; e_irq = 0; e_ack = 0; e_pend = 0;
      e_rgb = '0; e_rgb_known = 1;
      return;
    end
    p1 = m_c;
    h = m_c % HT;
    v = m_c / HT;
    e_hs    = !(h >= HA + 2 && h < HA + 4);
    e_vs    = (v != VA + 1);
    e_valid = (h < HA) && (v < VA);
    e_irq   = (m_c == SWAP_IDX);
    e_rgb = '0;
    e_rgb_known = 1;
    if (e_valid && !m_blank) begin
      pi = v * HA + h;
      e_rgb = m_buf[m_front][pi];
      e_rgb_known = m_known[m_front][pi];
    end
    acc = we && !m_ack;
    bk  = !m_front;
    if (e_irq && m_pend) begin
      m_front = !m_front;
      m_pend  = 0;
    end
    if (acc) begin
      pi = int'(addr >> 2);
      if (pi < NPIX) begin
        if (strb[0]) m_buf[bk][pi][7:0]   = wdata[7:0];
        if (strb[1]) m_buf[bk][pi][15:8]  = wdata[15:8];
        if (strb[2]) m_buf[bk][pi][23:16] = wdata[23:16];
        m_known[bk][pi] = m_known[bk][pi] || (strb[2:0] == 3'b111);
      end else if (addr == CTRL1 && strb[0]) begin
        if (wdata[0]) m_pend = 1;
        m_blank = wdata[1];
      end
    end
    m_ack  = acc;
    e_ack  = acc;
    e_pend = m_pend;
    m_c = (m_c + 1) % FT;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    if (clrn2) begin
      p2 = c2;
      c2 = (c2 + 1) % FT;
    end else begin
      c2 = 0;
      p2 = -1;
    end
    @(negedge clk);
    check("hsync", hs, e_hs);
    check("vsync", vs, e_vs);
    check("valid", vld, e_valid);
    check("vblank_irq", irq, e_irq);
    check("ready", ready, e_ack);
    check("swap_pending", pend, e_pend);
    if (e_rgb_known) check("rgb", {r, g, b}, e_rgb);
  endtask

  task automatic bus_write(input bit sel, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n = 0;
    if (sel) begin addr2 = a; wdata2 = d; strb2 = s; we2 = 1; end
    else     begin addr  = a; wdata  = d; strb  = s; we  = 1; end
    do begin
      tick();
      n++;
    end while (!(sel ? ready2 : ready) && n < 4);
    check(sel ? "ack2" : "ack1", sel ? ready2 : ready, 1'b1);
    we  = 0;
    we2 = 0;
  endtask

  task automatic wait_pos(input bit sel, input int h, input int v);
    int n = 0;
    while ((sel ? p2 : p1) != v * HT + h && n < 2 * FT) begin
      tick();
      n++;
    end
    check("wait_pos", (sel ? p2 : p1), v * HT + h);
  endtask

  task automatic wait_irq();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!irq && n < 2 * FT);
    check("wait_irq", irq, 1'b1);
  endtask

  task automatic wait_pend_clear(input bit sel);
    int n = 0;
    while ((sel ? pend2 : pend) && n < 2 * FT) begin
      tick();
      n++;
    end
    check("wait_pend_clear", sel ? pend2 : pend, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, nh, first, n;
    logic [31:0] cd;
    logic [3:0]  cs;

    clrn = 0; clrn2 = 0;
    we = 0; we2 = 0; addr = '0; addr2 = '0; wdata = '0; wdata2 = '0; strb = '0; strb2 = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NPIX; i++) begin
        m_buf[k][i] = '0;
        m_known[k][i] = 0;
      end
    repeat (3) tick();
    check("rst2_hsync", hs2, 1'b1);
    check("rst2_vsync", vs2, 1'b1);
    check("rst2_valid", vld2, 1'b0);
    check("rst2_rgb", {r2, g2, b2}, 24'h0);
    clrn = 1; clrn2 = 1;

    // Raster timing over two frames, then directed line and frame measurements.
    repeat (2 * FT) tick();
    wait_pos(0, 0, 0);
    nv = 0; nh = 0; first = -1;
    for (int i = 0; i < HT; i++) begin
      if (vld) nv++;
      if (!hs) begin
        nh++;
        if (first < 0) first = p1;
      end
      tick();
    end
    check("valid_per_line", nv, 8);
    check("hs_low_cycles", nh, 2);
    check("hs_low_first_h", first, 10);
    wait_pos(0, 0, 0);
    nv = 0; first = -1;
    for (int i = 0; i < FT; i++) begin
      if (!vs) begin
        nv++;
        if (first < 0) first = p1;
      end
      tick();
    end
    check("vs_low_cycles", nv, HT);
    check("vs_low_first_pos", first, 5 * HT);
    wait_irq();
    n = 0;
    do begin
      tick();
      n++;
    end while (!irq && n < 2 * FT);
    check("frame_period", n, FT);

    // Fill both buffers so every displayed pixel is defined.
    for (int i = 0; i < NPIX; i++) bus_write(0, i * 4, $urandom, 4'b0111);
    bus_write(0, CTRL1, 32'h1, 4'b0001);
    wait_pend_clear(0);
    for (int i = 0; i < NPIX; i++) bus_write(0, i * 4, $urandom, 4'b1111);

    // Swap: new pixel 0 appears after the frame-synchronous toggle.
    bus_write(0, 0, 32'h00FF0000, 4'b0111);
    bus_write(0, CTRL1, 32'h1, 4'b0001);
    check("swap_pend_set", pend, 1'b1);
    wait_irq();
    check("swap_pend_cleared", pend, 1'b0);
    wait_pos(0, 0, 0);
    check("swap_px0", {r, g, b}, 24'hFF0000);

    // Strobed write into the back buffer leaves the front view alone.
    bus_write(0, 12, 32'h0, 4'b0111);
    bus_write(0, 12, 32'h00AABBCC, 4'b0101);
    wait_pos(0, 3, 0);
    check("front_px3_unchanged", {r, g, b}, m_buf[m_front][3]);
    bus_write(0, CTRL1, 32'h1, 4'b0001);
    wait_irq();
    wait_pos(0, 3, 0);
    check("strobe_px3", {r, g, b}, 24'hAA00CC);

    // Control write accepted exactly on the swap-point edge.
    bus_write(0, 12, 32'h00123456, 4'b0111);
    tick();
    n = 0;
    while (m_c != SWAP_IDX && n < 2 * FT) begin
      tick();
      n++;
    end
    bus_write(0, CTRL1, 32'h1, 4'b0001);
    check("coinc_irq", irq, 1'b1);
    check("coinc_pend", pend, 1'b1);
    wait_pos(0, 3, 0);
    check("coinc_no_toggle", {r, g, b}, 24'hAA00CC);
    wait_irq();
    check("coinc_pend_cleared", pend, 1'b0);
    wait_pos(0, 3, 0);
    check("coinc_toggled", {r, g, b}, 24'h123456);

    // Blank keeps timing, zeroes colour; out-of-range write is acked and dropped.
    bus_write(0, CTRL1, 32'h2, 4'b0001);
    wait_pos(0, 0, 0);
    check("blank_valid", vld, 1'b1);
    check("blank_rgb", {r, g, b}, 24'h0);
    bus_write(0, 40 * 4, $urandom, 4'b1111);
    bus_write(0, CTRL1, 32'h1, 4'b0001);
    wait_irq();
    repeat (FT) tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      n = $urandom_range(0, 9);
      if (n < 7) begin
        bus_write(0, $urandom_range(0, NPIX - 1) * 4 + $urandom_range(0, 3), $urandom, 4'($urandom));
      end else if (n < 8) begin
        bus_write(0, $urandom_range(NPIX, 63) * 4, $urandom, 4'($urandom));
      end else begin
        cd = $urandom;
        cd[1] = ($urandom_range(0, 3) == 0);
        cs = 4'($urandom);
        if ($urandom_range(0, 3) != 0) cs[0] = 1'b1;
        bus_write(0, CTRL1, cd, cs);
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    // SCALE=2 instance: replication across pixels and lines.
    for (int i = 0; i < 8; i++) bus_write(1, i * 4, 32'h101010 * (i + 1), 4'b0111);
    bus_write(1, CTRL2, 32'h1, 4'b0001);
    wait_pend_clear(1);
    for (int i = 0; i < 8; i++) bus_write(1, i * 4, 32'h010203 * (i + 1), 4'b0111);
    wait_pos(1, 0, 0);
    check("s2_h0", {r2, g2, b2}, 24'h101010);
    tick();
    check("s2_h1", {r2, g2, b2}, 24'h101010);
    tick();
    check("s2_h2", {r2, g2, b2}, 24'h202020);
    tick();
    check("s2_h3", {r2, g2, b2}, 24'h202020);
    tick();
    check("s2_h4", {r2, g2, b2}, 24'h303030);
    wait_pos(1, 2, 1);
    check("s2_line1_h2", {r2, g2, b2}, 24'h202020);
    wait_pos(1, 2, 2);
    check("s2_line2_h2", {r2, g2, b2}, 24'h606060);

    // Asynchronous reset mid-line with a swap request and a write in flight.
    wait_pos(1, 1, 0);
    bus_write(1, CTRL2, 32'h1, 4'b0001);
    check("s2_pre_rst_pend", pend2, 1'b1);
    check("s2_pre_rst_valid", vld2, 1'b1);
    addr2 = 0; wdata2 = 32'hDEADBEEF; strb2 = 4'b0111; we2 = 1;
    #2 clrn2 = 0;
    #1;
    check("s2_rst_hsync", hs2, 1'b1);
    check("s2_rst_vsync", vs2, 1'b1);
    check("s2_rst_valid", vld2, 1'b0);
    check("s2_rst_rgb", {r2, g2, b2}, 24'h0);
    check("s2_rst_irq", irq2, 1'b0);
    check("s2_rst_ready", ready2, 1'b0);
    check("s2_rst_pend", pend2, 1'b0);
    tick();
    tick();
    we2 = 0;
    clrn2 = 1;
    tick();
    check("s2_restart_pos", p2, 0);
    check("s2_restart_valid", vld2, 1'b1);
    check("s2_restart_px0", {r2, g2, b2}, 24'h010203);
    check("s2_restart_pend", pend2, 1'b0);
    tick();
    tick();
    check("s2_restart_px1", {r2, g2, b2}, 24'h020406);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
